lbm_sweep_ctrl: RTL and testbench
=================================

Name: lbm_sweep_ctrl

Overview:
Sequences one LBM time step per full sweep of the 16x16 distribution RAM. For each node it reads the 9x32-bit distribution vector and hands it to the collision datapath over a valid/ready handshake. It then writes the returned vector back to the same address, repeating for a programmed number of steps. While idle, it grants the RAM port to a host/init/readout master.

Parameters:
NX, 16, lattice width in nodes
NY, 16, lattice height in nodes
DEPTH, NX*NY, RAM entries
ADDRESS_WIDTH, $clog2(DEPTH), RAM address width
DATA_WIDTH, 32*9, distribution vector width
STEP_WIDTH, 16, step counter width

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
start  in  1  pulse: begin run (sampled in IDLE only)
num_steps  in  STEP_WIDTH  steps to run, latched on accepted start
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at run end
step_count  out  STEP_WIDTH  completed steps in current/last run
ram_address  out  ADDRESS_WIDTH  to RAM address
ram_WE  out  1  to RAM write enable
ram_data_in  out  DATA_WIDTH  to RAM write data
ram_data_out  in  DATA_WIDTH  from RAM, combinational read of ram_address
col_valid  out  1  vector offered to collision unit
col_ready  in  1  collision unit accepts
col_data  out  DATA_WIDTH  = ram_data_out
res_valid  in  1  collided vector available
res_ready  out  1  controller accepts result
res_data  in  DATA_WIDTH  collided vector
host_address  in  ADDRESS_WIDTH  host access address
host_WE  in  1  host write enable
host_data_in  in  DATA_WIDTH  host write data
host_grant  out  1  high in IDLE: host owns RAM port
stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (Reset_n=0 at posedge): state IDLE; node, step_count, stall_cycles are 0; done=0. ram_WE is forced 0 combinationally while Reset_n=0. Reset mid-run aborts with no partial write and no done pulse.
- States: IDLE, ISSUE, WAIT, WRITE, FINISH.
- IDLE: host_grant=1; ram_address/ram_WE/ram_data_in = host_* pass-through. col_valid=0, res_ready=0.
  - start=1: latch num_steps; clear step_count and node.
  - Latched value 0: go to FINISH. Otherwise go to ISSUE.
- ISSUE: ram_address=node, ram_WE=0, col_valid=1, col_data=ram_data_out.
  - col_valid&&col_ready: go to WAIT.
  - col_valid holds, and col_data stays stable, until accepted.
- WAIT: res_ready=1.
  - res_valid: latch res_data into a result register and go to WRITE.
- WRITE: ram_address=node, ram_WE=1, ram_data_in=result register.
  - node<DEPTH-1: node+1, then ISSUE.
  - node==DEPTH-1: node=0 and step_count+1. If the new step_count==latched num_steps, go to FINISH; otherwise go to ISSUE.
- FINISH: done=1 for exactly one cycle, then IDLE. step_count holds until the next accepted start.
- Minimum cost is 3 cycles/node (ISSUE, WAIT, WRITE) and 3*DEPTH cycles/step with zero-latency collision.
- start outside IDLE is ignored. host_WE outside IDLE is ignored: no host write reaches the RAM.
- Only one outstanding vector at a time; no pipelining across nodes.
- step_count does not wrap in normal use: num_steps bounds it.

Optional Feature:
- Macro LBM_SWEEP_PERF_EN.
- Defined: stall_cycles increments each cycle in ISSUE with col_ready=0 or in WAIT with res_valid=0. It saturates at 2^32-1, clears on accepted start, and holds after done.
- Undefined: stall_cycles is tied to 0 and no counter logic is synthesized.

Decomposition:
- Package lbm_pkg holds:
  - constants NX, NY, Q=9, DIST_WIDTH=32
  - typedefs node_addr_t and dist_vec_t (logic signed [Q*DIST_WIDTH-1:0])
  - enum sweep_state_t
- No sub-module: FSM, counters and host mux stay in one module.

Test Plan:
- Host writes node 5 = 0x...01 pattern in IDLE, start with num_steps=1, collision = +1 per lane, zero latency: after done, node 5 reads pattern+1 in every lane. done occurs 3*256+1 cycles after start.
- num_steps=3 with +1 collision: every lane ends at initial+3, step_count=3, exactly one done pulse.
- num_steps=0: done pulses the cycle after FINISH entry, no ram_WE, step_count=0.
- Random col_ready/res_valid backpressure: col_data stable while col_valid&&!col_ready, final RAM image matches the model. With LBM_SWEEP_PERF_EN, stall_cycles equals the injected stall count.
- host_WE=1 and start=1 while busy: RAM unchanged by host, run unaffected, host_grant=0.
- Reset_n=0 in the WRITE state at node 100: no write that cycle, next cycle IDLE, busy=0, step_count=0, host_grant=1.

Source files
------------

// File: rtl/lbm_pkg.sv
// Shared constants, types and FSM encoding for the LBM sweep controller.
package lbm_pkg;

  localparam int NX         = 16;
  localparam int NY         = 16;
  localparam int Q          = 9;
  localparam int DIST_WIDTH = 32;

  typedef logic [$clog2(NX*NY)-1:0]      node_addr_t;
  typedef logic signed [Q*DIST_WIDTH-1:0] dist_vec_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_FINISH
  } sweep_state_t;

endpackage

// File: rtl/lbm_sweep_ctrl.sv
// LBM sweep controller: one read-collide-write per node, one step per full RAM sweep.
// Optional stall counter enabled by defining LBM_SWEEP_PERF_EN.
module lbm_sweep_ctrl
  import lbm_pkg::*;
#(
  parameter int NX            = lbm_pkg::NX,
  parameter int NY            = lbm_pkg::NY,
  parameter int DEPTH         = NX*NY,
  parameter int ADDRESS_WIDTH = $clog2(DEPTH),
  parameter int DATA_WIDTH    = lbm_pkg::Q*lbm_pkg::DIST_WIDTH,
  parameter int STEP_WIDTH    = 16
)(
  input  logic                     Clk,
  input  logic                     Reset_n,
  input  logic                     start,
  input  logic [STEP_WIDTH-1:0]    num_steps,
  output logic                     busy,
  output logic                     done,
  output logic [STEP_WIDTH-1:0]    step_count,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_WE,
  output logic [DATA_WIDTH-1:0]    ram_data_in,
  input  logic [DATA_WIDTH-1:0]    ram_data_out,
  output logic                     col_valid,
  input  logic                     col_ready,
  output logic [DATA_WIDTH-1:0]    col_data,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [DATA_WIDTH-1:0]    res_data,
  input  logic [ADDRESS_WIDTH-1:0] host_address,
  input  logic                     host_WE,
  input  logic [DATA_WIDTH-1:0]    host_data_in,
  output logic                     host_grant,
  output logic [31:0]              stall_cycles
);

  sweep_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] node_q, node_d;
  logic [STEP_WIDTH-1:0]    step_q, step_d, nsteps_q, nsteps_d;
  logic [DATA_WIDTH-1:0]    res_q, res_d;
  logic                     we;
  logic                     last_node;

  assign last_node = (node_q == ADDRESS_WIDTH'(DEPTH-1));

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      node_q   <= '0;
      step_q   <= '0;
      nsteps_q <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      node_q   <= node_d;
      step_q   <= step_d;
      nsteps_q <= nsteps_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    step_d      = step_q;
    nsteps_d    = nsteps_q;
    res_d       = res_q;
    ram_address = node_q;
    ram_data_in = res_q;
    we          = 1'b0;
    col_valid   = 1'b0;
    res_ready   = 1'b0;
    done        = 1'b0;
    host_grant  = 1'b0;
    case (state_q)
      S_IDLE: begin
        host_grant  = 1'b1;
        ram_address = host_address;
        ram_data_in = host_data_in;
        we          = host_WE;
        if (start) begin
          nsteps_d = num_steps;
          step_d   = '0;
          node_d   = '0;
          state_d  = (num_steps == '0) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        col_valid = 1'b1;
        if (col_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        res_ready = 1'b1;
        if (res_valid) begin
          res_d   = res_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        we = 1'b1;
        if (!last_node) begin
          node_d  = node_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          node_d  = '0;
          step_d  = step_q + 1'b1;
          state_d = (step_d == nsteps_q) ? S_FINISH : S_ISSUE;
        end
      end
      S_FINISH: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset kills any write in the same cycle, including host writes.
  assign ram_WE     = we & Reset_n;
  assign col_data   = ram_data_out;
  assign busy       = (state_q != S_IDLE);
  assign step_count = step_q;

`ifdef LBM_SWEEP_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic        stall_inc;

  assign stall_inc = ((state_q == S_ISSUE) && !col_ready) ||
                     ((state_q == S_WAIT) && !res_valid);

  always_comb begin
    stall_d = stall_q;
    if (state_q == S_IDLE && start) stall_d = '0;
    else if (stall_inc && stall_q != '1) stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_lbm_sweep_ctrl.sv
// Randomized bench for lbm_sweep_ctrl: RAM + collision responder + whole-image model.
module tb_lbm_sweep_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 288;
  localparam int SW    = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset_n = 1'b0, start = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic          busy, done, ram_WE, col_valid, res_ready, host_grant;
  logic [SW-1:0] step_count;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in, ram_data_out, col_data;
  logic          col_ready = 1'b0, res_valid = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic [AW-1:0] host_address = '0;
  logic          host_WE = 1'b0;
  logic [DW-1:0] host_data_in = '0;
  logic [31:0]   stall_cycles;

  lbm_sweep_ctrl dut (
    .Clk(clk), .Reset_n(Reset_n), .start(start), .num_steps(num_steps),
    .busy(busy), .done(done), .step_count(step_count),
    .ram_address(ram_address), .ram_WE(ram_WE), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .col_valid(col_valid), .col_ready(col_ready),
    .col_data(col_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .host_address(host_address), .host_WE(host_WE),
    .host_data_in(host_data_in), .host_grant(host_grant), .stall_cycles(stall_cycles)
  );

  // Environment RAM with combinational read.
  logic [DW-1:0] mem [DEPTH];
  assign ram_data_out = mem[ram_address];
  always @(posedge clk) if (ram_WE) mem[ram_address] <= ram_data_in;

  int checks = 0, errors = 0;
  logic [DW-1:0] gold [DEPTH];
  bit            bp = 1'b0, pend = 1'b0, stall_prev = 1'b0;
  logic [DW-1:0] exp_res = '0, prev_col = '0;
  int            exp_node = 0, inj = 0, done_cnt = 0, wr_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] add_lanes(input logic [DW-1:0] v, input int k);
    logic [DW-1:0] r;
    for (int l = 0; l < 9; l++) r[l*32 +: 32] = v[l*32 +: 32] + 32'(k);
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] r;
    for (int l = 0; l < 9; l++) r[l*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic mem_chk(input string name);
    int bad = 0;
    for (int a = 0; a < DEPTH; a++) if (mem[a] !== gold[a]) bad++;
    chk(name, bad, 0);
  endtask

  // Per-cycle checker plus collision responder (+1 per lane).
  always @(negedge clk) begin
    if (!Reset_n) begin
      pend = 1'b0; stall_prev = 1'b0; col_ready = 1'b0; res_valid = 1'b0;
    end else begin
      if (!busy) begin
        chk("idle_grant", host_grant, 1'b1);
        chk("idle_addr", ram_address, host_address);
        chk("idle_we", ram_WE, host_WE);
        chk("idle_wdata", ram_data_in, host_data_in);
        chk("idle_handshake", {col_valid, res_ready}, 2'b00);
      end else begin
        chk("busy_grant", host_grant, 1'b0);
        if (col_valid) begin
          chk("issue_addr", ram_address, exp_node);
          chk("issue_data", col_data, mem[exp_node]);
          chk("issue_we", ram_WE, 1'b0);
          if (stall_prev) chk("col_data_stable", col_data, prev_col);
        end
        if (ram_WE) begin
          chk("write_addr", ram_address, exp_node);
          chk("write_data", ram_data_in, exp_res);
          exp_node = (exp_node + 1) % DEPTH;
        end
      end
      if (ram_WE) wr_cnt++;
      if (done) done_cnt++;
      col_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      res_valid = pend && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
      res_data  = pend ? exp_res : rand_vec();
      stall_prev = col_valid && !col_ready;
      prev_col   = col_data;
      if (col_valid && !col_ready) inj++;
      if (res_ready && !res_valid) inj++;
      if (col_valid && col_ready) begin exp_res = add_lanes(col_data, 1); pend = 1'b1; end
      if (res_ready && res_valid) pend = 1'b0;
    end
  end

  task automatic run(input int n, input bit bp_en, input bit disturb, output int cyc);
    bp = bp_en; num_steps = SW'(n); start = 1'b1; exp_node = 0; inj = 0;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
    while (!done && cyc < 30000) begin
      if (disturb) begin
        start = 1'($urandom); num_steps = SW'($urandom); host_WE = 1'($urandom);
        host_address = AW'($urandom); host_data_in = rand_vec();
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; host_WE = 1'b0;
    chk("run_done_reached", done, 1'b1);
  endtask

  function automatic int exp_stall();
`ifdef LBM_SWEEP_PERF_EN
    return inj;
`else
    return 0;
`endif
  endfunction

  initial begin
    int cyc, w0, d0, k;
    logic [DW-1:0] d;
    host_WE = 1'b1; host_address = 8'd3; host_data_in = rand_vec();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_step", step_count, 0);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_grant", host_grant, 1'b1);
    chk("rst_we_forced", ram_WE, 1'b0);
    chk("rst_colv", col_valid, 1'b0);
    host_WE = 1'b0; Reset_n = 1'b1;
    chk("model_wrap", add_lanes({{8{32'h7}}, 32'hFFFF_FFFF}, 1), {{8{32'h8}}, 32'h0});

    // Load RAM through the host port.
    for (int a = 0; a < DEPTH; a++) begin
      d = rand_vec();
      if (a == 5) d = {9{32'h1}};
      if (a == 7) d[95:64] = 32'hFFFF_FFFF;
      host_address = AW'(a); host_data_in = d; host_WE = 1'b1; gold[a] = d;
      @(posedge clk); #1;
    end
    host_WE = 1'b0; host_address = 8'd5; #1;
    chk("host_read5", ram_data_out, {9{32'h1}});

    // One step, zero-latency collision.
    w0 = wr_cnt; d0 = done_cnt;
    run(1, 1'b0, 1'b0, cyc);
    chk("latency_1step", cyc, 769);
    chk("step_count_1", step_count, 1);
    chk("writes_1step", wr_cnt - w0, 256);
    for (int a = 0; a < DEPTH; a++) gold[a] = add_lanes(gold[a], 1);
    @(posedge clk); #1;
    chk("done_pulses_1", done_cnt - d0, 1);
    mem_chk("image_1step");
    host_address = 8'd5; #1;
    chk("node5_after_1", ram_data_out, {9{32'h2}});
    host_address = 8'd7; #1;
    chk("node7_lane_wrap", ram_data_out[95:64], 32'h0);

    // Three steps with backpressure and host/start interference.
    d0 = done_cnt;
    run(3, 1'b1, 1'b1, cyc);
    chk("step_count_3", step_count, 3);
    chk("stall_count", stall_cycles, exp_stall());
    for (int a = 0; a < DEPTH; a++) gold[a] = add_lanes(gold[a], 3);
    @(posedge clk); #1;
    chk("post_busy", busy, 1'b0);
    chk("post_done_low", done, 1'b0);
    chk("done_pulses_3", done_cnt - d0, 1);
    chk("stall_hold", stall_cycles, exp_stall());
    mem_chk("image_3step");
    host_address = 8'd5; #1;
    chk("node5_after_4", ram_data_out, {9{32'h5}});

    // Zero steps.
    w0 = wr_cnt; d0 = done_cnt;
    run(0, 1'b1, 1'b0, cyc);
    chk("zero_latency", cyc, 1);
    chk("zero_step", step_count, 0);
    @(posedge clk); #1;
    chk("zero_writes", wr_cnt - w0, 0);
    chk("zero_done_pulses", done_cnt - d0, 1);
    mem_chk("image_zero");

    // Reset while writing node 100.
    d0 = done_cnt; bp = 1'b0; num_steps = 16'd1; start = 1'b1; exp_node = 0; inj = 0;
    @(posedge clk); #1;
    start = 1'b0; k = 0;
    while (!(ram_WE && ram_address == 8'd100) && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    chk("reach_node100", {ram_WE, ram_address}, {1'b1, 8'd100});
    Reset_n = 1'b0; #1;
    chk("rst_no_write", ram_WE, 1'b0);
    @(posedge clk); #1;
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_step", step_count, 0);
    chk("midrst_grant", host_grant, 1'b1);
    chk("midrst_stall", stall_cycles, 0);
    Reset_n = 1'b1; exp_node = 0;
    for (int a = 0; a < 100; a++) gold[a] = add_lanes(gold[a], 1);
    @(posedge clk); #1;
    chk("midrst_no_done", done_cnt - d0, 0);
    mem_chk("image_midrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
